// File: rtl/axil_console_pkg.sv
// axil_console_pkg: register map, STATUS layout and UART states for axil_console_uart
package axil_console_pkg;
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_EXIT   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_COUNT = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/console_fifo.sv
// console_fifo: synchronous FIFO with registered occupancy count
module console_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic we, re;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign we    = push && !full;
    assign re    = pop && !empty;
    assign dout  = mem[rp];
    always_ff @(posedge clk)
        if (we)
            mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= we ? wp + AW'(1) : wp;
            rp    <= re ? rp + AW'(1) : rp;
            count <= count + (AW+1)'(we) - (AW+1)'(re);
        end
    end
endmodule

// File: rtl/axil_console_uart.sv
// axil_console_uart: AXI4-Lite console/exit peripheral with FIFO-buffered 8N1 UART transmitter
module axil_console_uart
    import axil_console_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic        uart_tx,
    output logic        exit_valid,
    output logic [31:0] exit_code
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLK_DIV);
    logic aw_lat, w_lat, ar_pend, w_strb0;
    logic [1:0] aw_off;
    logic [31:0] w_data, rd_val, rd_hold, status;
    logic push_req, commit, push, pop, full, empty;
    logic [7:0] dout, sh, sh_n;
    logic [CW-1:0] count;
    uart_state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic tx_n, baud_end;
    logic unused_ok;
    assign unused_ok = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_araddr[31:4], s_axi_araddr[1:0],
                         s_axi_awprot, s_axi_arprot, s_axi_wstrb[3:1]};
    // a full FIFO holds the TXDATA commit, and with it bvalid, until the UART pops
    assign push_req = aw_off == REG_TXDATA && w_strb0;
    assign commit   = aw_lat && w_lat && !s_axi_bvalid && !(push_req && full);
    assign push     = commit && push_req;
    console_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(w_data[7:0]),
        .dout(dout), .full(full), .empty(empty), .count(count)
    );
    always_comb begin
        status = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL] = full;
        status[ST_BUSY] = state != IDLE;
        status[ST_COUNT +: 8] = 8'(count);
        rd_val = s_axi_araddr[3:2] == REG_STATUS ? status : s_axi_araddr[3:2] == REG_EXIT ? exit_code : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            aw_lat        <= 1'b0;
            w_lat         <= 1'b0;
            ar_pend       <= 1'b0;
            aw_off        <= '0;
            w_data        <= '0;
            w_strb0       <= 1'b0;
            rd_hold       <= '0;
            exit_valid    <= 1'b0;
            exit_code     <= '0;
        end else begin
            s_axi_awready <= s_axi_awvalid && !aw_lat && !s_axi_awready;
            s_axi_wready  <= s_axi_wvalid && !w_lat && !s_axi_wready;
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !ar_pend && !s_axi_arready;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_lat <= 1'b1;
                aw_off <= s_axi_awaddr[3:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_lat   <= 1'b1;
                w_data  <= s_axi_wdata;
                w_strb0 <= s_axi_wstrb[0];
            end
            if (commit) begin
                aw_lat       <= 1'b0;
                w_lat        <= 1'b0;
                s_axi_bvalid <= 1'b1;
                if (aw_off == REG_EXIT && !exit_valid) begin
                    exit_valid <= 1'b1;
                    exit_code  <= w_data;
                end
            end else if (s_axi_bready)
                s_axi_bvalid <= 1'b0;
            if (s_axi_arvalid && s_axi_arready) begin
                ar_pend <= 1'b1;
                rd_hold <= rd_val;
            end
            if (ar_pend) begin
                ar_pend      <= 1'b0;
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_hold;
            end else if (s_axi_rready)
                s_axi_rvalid <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
            uart_tx <= tx_n;
        end
    end
    // STOP chains straight into START when another byte is waiting
    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bit_n    = bit_idx;
        sh_n     = sh;
        tx_n     = uart_tx;
        pop      = 1'b0;
        baud_end = baud == BW'(CLK_DIV - 1);
        case (state)
            IDLE:
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = dout;
                    state_n = START;
                    baud_n  = '0;
                    tx_n    = 1'b0;
                end
            START: begin
                baud_n = baud_end ? '0 : baud + BW'(1);
                if (baud_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = sh[0];
                end
            end
            DATA: begin
                baud_n = baud_end ? '0 : baud + BW'(1);
                if (baud_end && bit_idx == 3'd7) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end else if (baud_end) begin
                    bit_n = bit_idx + 3'd1;
                    sh_n  = sh >> 1;
                    tx_n  = sh[1];
                end
            end
            default: begin
                baud_n = baud_end ? '0 : baud + BW'(1);
                if (baud_end && !empty) begin
                    pop     = 1'b1;
                    sh_n    = dout;
                    state_n = START;
                    tx_n    = 1'b0;
                end else if (baud_end)
                    state_n = IDLE;
            end
        endcase
    end
endmodule

// File: doc/axil_console_uart.md
# axil_console_uart

AXI4-Lite slave peripheral mapped at 0x1000_0000 on the picorv32_axi memory bus. It sits beside the main memory and receives the CPU's console and exit writes. Console bytes are buffered in a FIFO and serialised as 8N1 UART. An exit register reports the firmware's exit code to the bench or top level.

## Interface
Parameters:
- CLK_DIV, 16, clock cycles per UART bit (≥2)
- FIFO_DEPTH, 16, TX FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake
- s_axi_awaddr  in  32  write address; only [3:2] decoded
- s_axi_awprot  in  3  ignored
- s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes; TXDATA push requires wstrb[0]
- s_axi_bvalid / s_axi_bready  out/in  1  write response (always OKAY, no bresp port)
- s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake
- s_axi_araddr  in  32  read address; only [3:2] decoded
- s_axi_arprot  in  3  ignored
- s_axi_rvalid / s_axi_rready  out/in  1  read data handshake
- s_axi_rdata  out  32  read data
- uart_tx  out  1  serial output, idle high
- exit_valid  out  1  sticky flag, set by the first EXIT write
- exit_code  out  32  value of the first EXIT write

## Operation
Register map, by offset [3:2]:
- 0 TXDATA: write pushes wdata[7:0]; reads as 0
- 1 EXIT: write latches the code into exit_code and sets exit_valid; later writes are ignored but still acknowledged
- 2 STATUS (read-only): [0] fifo_empty, [1] fifo_full, [2] tx_busy, [15:8] fifo_count
- 3 reserved: reads as 0, writes ignored

Write path:
- AW and W are latched independently. awready pulses for one cycle when awvalid is high and no address is latched; wready behaves the same for data.
- Once both are latched and bvalid is low, the write commits.
- A TXDATA commit while the FIFO is full stalls until space frees. bvalid stays low during the stall (backpressure).
- The commit clears both latches and raises bvalid. bvalid holds until bready.

Read path:
- arready pulses for one cycle when arvalid is high, rvalid is low and no read is pending.
- rdata and rvalid are registered on the following edge. Both hold until rready.

UART FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
- Each state lasts CLK_DIV cycles, except DATA, which lasts 8×CLK_DIV. A frame is 10×CLK_DIV cycles.
- IDLE pops the FIFO head when the FIFO is non-empty.
- When the FIFO is non-empty at the end of STOP, IDLE immediately starts the next frame: no extra idle bit.
- tx_busy is high in every state except IDLE.

## Timing
- Reset values: all ready/valid outputs 0, s_axi_rdata 0, uart_tx 1, exit_valid 0, exit_code 0, FIFO empty, FSM IDLE, bit counter 0.
- Reset mid-frame: uart_tx is 1 after the reset edge. The FIFO is flushed and pending AXI transactions are dropped.
- Write latency: AW and W presented together with awvalid=wvalid=1 at edge E0 → readies high after E0 → handshake at E1 → commit/push at E2 → bvalid high after E2.
- Read latency: arready high after E0 → handshake at E1 → rvalid high with data after E2.
- Reads and writes are independent and may complete in the same cycle.
- A push and a pop in the same cycle leave fifo_count unchanged. Push is permitted only when the registered count is below FIFO_DEPTH, even if a pop occurs that cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- STATUS reflects the state registered at the AR handshake edge.
- A TXDATA write with wstrb[0]=0 is acknowledged without a push.
- The first byte pushed into an empty, idle FIFO drives the start bit (uart_tx=0) 1 cycle after the push edge.

## Structure
- Package axil_console_pkg holds:
  - register offset constants (REG_TXDATA=0, REG_EXIT=1, REG_STATUS=2)
  - STATUS bit positions
  - the UART state enum (IDLE, START, DATA, STOP)
- Sub-module console_fifo: synchronous FIFO (DEPTH, WIDTH=8). Ports: push, pop, din, dout, full, empty, count.
- The top level contains the AXI-Lite slave logic, the register file and the UART FSM with its baud counter.

## Test plan
- Write 0x41 to TXDATA with CLK_DIV=4 → bvalid 3 edges after valid. uart_tx shows 0, then 1,0,0,0,0,0,1,0, then 1, each level held 4 cycles.
- Push 17 bytes back-to-back with FIFO_DEPTH=16 and the UART stalled mid-frame → the 17th bvalid is delayed until the first pop. All 17 bytes then appear in order with no idle gap between frames.
- Write 0 to EXIT, then write 5 → exit_valid=1, exit_code=0 after the first write. Both writes return bvalid.
- Read STATUS after pushing 3 bytes into an idle FIFO → rdata shows busy=1 and count=2.
- Issue AW 2 cycles before W, then W 2 cycles before AW → each commits exactly once, with bvalid after the later handshake plus 1 edge.
- Assert reset 3 bit-times into a frame with 4 bytes queued → uart_tx=1 next cycle, STATUS reads 0x0000_0001, no further frames.
